hack_alu_mul_sequencer: RTL



---
 rtl/hack_alu_mul_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hack_alu_mul_sequencer.sv
// hack_alu_mul_sequencer: multi-cycle unsigned 16-bit shift-and-add multiplier
// that drives a Hack ALU in x+y mode for both the accumulate and the doubling
// steps, and stops as soon as no multiplier bits remain.

// HackAlu: the standard Hack ALU datapath (zx,nx,zy,ny,f,no); only the word
// result is needed here, so the zr/ng flags are not brought out.
module HackAlu (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic [5:0]  i_ctrl,
  output logic [15:0] o_out
);

  logic [15:0] w_xZero;
  logic [15:0] w_xNeg;
  logic [15:0] w_yZero;
  logic [15:0] w_yNeg;
  logic [15:0] w_fOut;

  // Control bits applied in Hack order: zero, negate, function, negate output
  always_comb begin
    w_xZero = i_ctrl[5] ? 16'h0000 : i_x;
    w_xNeg  = i_ctrl[4] ? ~w_xZero : w_xZero;
    w_yZero = i_ctrl[3] ? 16'h0000 : i_y;
    w_yNeg  = i_ctrl[2] ? ~w_yZero : w_yZero;
    w_fOut  = i_ctrl[1] ? (w_xNeg + w_yNeg) : (w_xNeg & w_yNeg);
    o_out   = i_ctrl[0] ? ~w_fOut : w_fOut;
  end

endmodule

module hack_alu_mul_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_product,
  output logic        o_ovf,
  output logic [5:0]  o_alu_ctrl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] CTRL_ADD = 6'b000010;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_p;
  logic [15:0] r_m;
  logic [15:0] r_q;
  logic        r_ovf;

  logic [15:0] w_aluX;
  logic [15:0] w_aluY;
  logic [15:0] w_aluOut;
  logic        w_carry;
  logic [15:0] w_qShift;
  logic        w_bitsPending;

  // ALU operand steering: accumulate P+M in ADD, double M+M in DBL, idle zero otherwise
  always_comb begin
    w_aluX = 16'h0000;
    w_aluY = 16'h0000;
    case (r_state)
      ADD: begin
        w_aluX = r_p;
        w_aluY = r_m;
      end
      DBL: begin
        w_aluX = r_m;
        w_aluY = r_m;
      end
      default: begin
        w_aluX = 16'h0000;
        w_aluY = 16'h0000;
      end
    endcase
  end

  HackAlu u_alu (
    .i_x    (w_aluX),
    .i_y    (w_aluY),
    .i_ctrl (o_alu_ctrl),
    .o_out  (w_aluOut)
  );

  // Unsigned wrap of the sum shows up as a result smaller than the x operand
  assign w_carry       = (w_aluOut < w_aluX);
  assign w_qShift      = r_q >> 1;
  assign w_bitsPending = (w_qShift != 16'h0000);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and state-decoded outputs; a zero multiplier skips the loop entirely
  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_alu_ctrl  = 6'b000000;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = (i_b == 16'h0000) ? DONE : ADD;
        end
      end
      ADD: begin
        o_busy      = 1'b1;
        o_alu_ctrl  = CTRL_ADD;
        w_nextState = DBL;
      end
      DBL: begin
        o_busy      = 1'b1;
        o_alu_ctrl  = CTRL_ADD;
        w_nextState = w_bitsPending ? ADD : DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, accumulate on set bits, double and shift,
  // flagging overflow only for carries that will actually reach the product
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p   <= 16'h0000;
      r_m   <= 16'h0000;
      r_q   <= 16'h0000;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_p   <= 16'h0000;
            r_m   <= i_a;
            r_q   <= i_b;
            r_ovf <= 1'b0;
          end
        end
        ADD: begin
          if (r_q[0]) begin
            r_p   <= w_aluOut;
            r_ovf <= r_ovf | w_carry;
          end
        end
        DBL: begin
          r_m   <= w_aluOut;
          r_q   <= w_qShift;
          r_ovf <= r_ovf | (w_carry & w_bitsPending);
        end
        default: begin
          r_p   <= r_p;
        end
      endcase
    end
  end

  assign o_product = r_p;
  assign o_ovf     = r_ovf;

endmodule
